// File: rtl/input_stretcher_pkg.sv
// Shared types and defaults for the button-input stretcher.
// Imported by the stretcher, its interface and the LSB isolator.
package input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE_WAIT
  } state_t;

  localparam int DEFAULT_WIDTH = 6;
  localparam int DEFAULT_HOLD  = 255;

endpackage

// File: rtl/input_stretcher_if.sv
// Button bus between synchronisers and the stretcher.
// The master drives buttons/clear; the slave returns the held value.
interface input_stretcher_if
  import input_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0] userin;
  logic             clear;
  logic [WIDTH-1:0] userin_out;
  logic             valid;
  logic             captured;
  logic             busy;
  logic [CNT_W-1:0] count;

  modport master (
    output userin,
    output clear,
    input  userin_out,
    input  valid,
    input  captured,
    input  busy,
    input  count
  );

  modport slave (
    input  userin,
    input  clear,
    output userin_out,
    output valid,
    output captured,
    output busy,
    output count
  );

endinterface

// File: rtl/input_lsb_isolate.sv
// Isolates the lowest-index set bit of a vector.
// Two's-complement trick: v & -v.
module input_lsb_isolate
  import input_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] lsb
);

  assign lsb = vec & (~vec + WIDTH'(1));

endmodule

// File: rtl/input_stretcher.sv
// Captures a non-zero button vector and holds it for HOLD_CYCLES.
// Optional single-channel capture and release-before-recapture.
module input_stretcher
  import input_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int CNT_W           = 8,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD,
  parameter bit REQUIRE_RELEASE = 1'b1,
  parameter bit ONEHOT_MODE     = 1'b0
) (
  input logic               clk,
  input logic               reset,
  input_stretcher_if.slave  bus
);

  if (HOLD_CYCLES < 1 ||
      HOLD_CYCLES > (1 << CNT_W) - 1) begin : g_bad_hold
    $error("input_stretcher: HOLD_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(HOLD_CYCLES - 1);

  logic [WIDTH-1:0] cap;
  logic             pressed;
  state_t           state;

  assign pressed = |bus.userin;

  if (ONEHOT_MODE) begin : g_onehot
    input_lsb_isolate #(
      .WIDTH(WIDTH)
    ) u_lsb (
      .vec(bus.userin),
      .lsb(cap)
    );
  end else begin : g_full
    assign cap = bus.userin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.userin_out <= '0;
      bus.valid      <= 1'b0;
      bus.captured   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.count      <= '0;
    end else begin
      bus.captured <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.clear && pressed) begin
            state          <= HOLD;
            bus.userin_out <= cap;
            bus.valid      <= 1'b1;
            bus.captured   <= 1'b1;
            bus.busy       <= 1'b1;
            bus.count      <= '0;
          end
        end
        HOLD: begin
          if (bus.clear || bus.count == LAST) begin
            bus.userin_out <= '0;
            bus.valid      <= 1'b0;
            bus.count      <= '0;
            // Stay busy while buttons must still be let go.
            if (REQUIRE_RELEASE && pressed) begin
              state <= RELEASE_WAIT;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            bus.count <= bus.count + CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (!pressed) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_stretcher.sv
// Self-checking bench: four stretcher configurations share stimulus
// and are compared every cycle against a countdown reference model.
module tb_input_stretcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] uin = '0;
  logic       clr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  localparam int HS [4] = '{4, 4, 7, 1};
  localparam int RR [4] = '{1, 0, 1, 0};
  localparam int OH [4] = '{0, 0, 1, 0};

  input_stretcher_if #(.WIDTH(6), .CNT_W(8)) ia ();
  input_stretcher_if #(.WIDTH(6), .CNT_W(8)) ib ();
  input_stretcher_if #(.WIDTH(6), .CNT_W(3)) ic ();
  input_stretcher_if #(.WIDTH(6), .CNT_W(8)) id ();

  assign ia.userin = uin;
  assign ia.clear  = clr;
  assign ib.userin = uin;
  assign ib.clear  = clr;
  assign ic.userin = uin;
  assign ic.clear  = clr;
  assign id.userin = uin;
  assign id.clear  = clr;

  input_stretcher #(
    .WIDTH(6), .CNT_W(8), .HOLD_CYCLES(4),
    .REQUIRE_RELEASE(1'b1), .ONEHOT_MODE(1'b0)
  ) ua (.clk(clk), .reset(rst), .bus(ia));

  input_stretcher #(
    .WIDTH(6), .CNT_W(8), .HOLD_CYCLES(4),
    .REQUIRE_RELEASE(1'b0), .ONEHOT_MODE(1'b0)
  ) ub (.clk(clk), .reset(rst), .bus(ib));

  input_stretcher #(
    .WIDTH(6), .CNT_W(3), .HOLD_CYCLES(7),
    .REQUIRE_RELEASE(1'b1), .ONEHOT_MODE(1'b1)
  ) uc (.clk(clk), .reset(rst), .bus(ic));

  input_stretcher #(
    .WIDTH(6), .CNT_W(8), .HOLD_CYCLES(1),
    .REQUIRE_RELEASE(1'b0), .ONEHOT_MODE(1'b0)
  ) ud (.clk(clk), .reset(rst), .bus(id));

  typedef struct {
    logic [5:0] val;
    int         left;
    bit         rel;
    bit         cap;
  } mdl_t;

  mdl_t m [4];

  function automatic logic [5:0] lowbit(logic [5:0] v);
    for (int b = 0; b < 6; b++)
      if (v[b]) return 6'(1 << b);
    return 6'd0;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      m[i].cap = 1'b0;
      if (rst) begin
        m[i].left = 0;
        m[i].rel  = 1'b0;
        m[i].val  = '0;
      end else if (m[i].left > 0) begin
        if (clr || m[i].left == 1) begin
          m[i].left = 0;
          m[i].rel  = (RR[i] == 1) && (uin != 0);
        end else begin
          m[i].left--;
        end
      end else if (m[i].rel) begin
        if (uin == 0) m[i].rel = 1'b0;
      end else if (!clr && uin != 0) begin
        m[i].val  = (OH[i] == 1) ? lowbit(uin) : uin;
        m[i].left = HS[i];
        m[i].cap  = 1'b1;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(int i, logic [5:0] uo, logic v,
                          logic c, logic b, logic [7:0] cnt);
    bit         h;
    logic [7:0] ecnt;
    h    = m[i].left > 0;
    ecnt = h ? 8'(HS[i] - m[i].left) : 8'd0;
    chk($sformatf("u%0d.userin_out", i), 32'(uo),
        h ? 32'(m[i].val) : 32'd0);
    chk($sformatf("u%0d.valid", i), 32'(v), 32'(h));
    chk($sformatf("u%0d.captured", i), 32'(c), 32'(m[i].cap));
    chk($sformatf("u%0d.busy", i), 32'(b),
        32'(h || m[i].rel));
    chk($sformatf("u%0d.count", i), 32'(cnt), 32'(ecnt));
  endtask

  task automatic tick(logic [5:0] u, logic c, logic r);
    uin = u;
    clr = c;
    rst = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_inst(0, ia.userin_out, ia.valid, ia.captured,
             ia.busy, ia.count);
    cmp_inst(1, ib.userin_out, ib.valid, ib.captured,
             ib.busy, ib.count);
    cmp_inst(2, ic.userin_out, ic.valid, ic.captured,
             ic.busy, {5'd0, ic.count});
    cmp_inst(3, id.userin_out, id.valid, id.captured,
             id.busy, id.count);
  endtask

  logic [5:0] cu;

  initial begin
    for (int i = 0; i < 4; i++) m[i] = '{6'd0, 0, 1'b0, 1'b0};

    tick(6'd0, 1'b0, 1'b1);
    tick(6'd0, 1'b0, 1'b1);
    chk("rst.uo", 32'(ia.userin_out), 32'd0);
    chk("rst.busy", 32'(ia.busy), 32'd0);
    chk("rst.count", 32'(ia.count), 32'd0);

    // Single-cycle press, 4-cycle hold.
    tick(6'b000100, 1'b0, 1'b0);
    chk("p1.uo", 32'(ia.userin_out), 32'h04);
    chk("p1.cap", 32'(ia.captured), 32'd1);
    chk("p1.cnt", 32'(ia.count), 32'd0);
    chk("h1.valid", 32'(id.valid), 32'd1);
    chk("h1.cap", 32'(id.captured), 32'd1);
    tick(6'd0, 1'b0, 1'b0);
    chk("p2.cap", 32'(ia.captured), 32'd0);
    chk("p2.cnt", 32'(ia.count), 32'd1);
    chk("h1.off", 32'(id.valid), 32'd0);
    tick(6'd0, 1'b0, 1'b0);
    tick(6'd0, 1'b0, 1'b0);
    chk("p4.cnt", 32'(ia.count), 32'd3);
    chk("p4.valid", 32'(ia.valid), 32'd1);
    tick(6'd0, 1'b0, 1'b0);
    chk("p5.uo", 32'(ia.userin_out), 32'd0);
    chk("p5.busy", 32'(ia.busy), 32'd0);

    tick(6'd0, 1'b0, 1'b1);
    // Long press: release-wait versus immediate recapture.
    for (int k = 1; k <= 20; k++) begin
      tick(6'b000010, 1'b0, 1'b0);
      if (k == 5) begin
        chk("rr.busy", 32'(ia.busy), 32'd1);
        chk("rr.uo", 32'(ia.userin_out), 32'd0);
        chk("nr.gap", 32'(ib.userin_out), 32'd0);
      end
      if (k == 6) chk("nr.recap", 32'(ib.captured), 32'd1);
      if (k == 20) chk("rr.still", 32'(ia.busy), 32'd1);
    end
    tick(6'd0, 1'b0, 1'b0);
    chk("rr.idle", 32'(ia.busy), 32'd0);
    tick(6'b000010, 1'b0, 1'b0);
    chk("rr.again", 32'(ia.captured), 32'd1);

    tick(6'd0, 1'b0, 1'b1);
    // One-hot capture ignores later input changes.
    tick(6'b110100, 1'b0, 1'b0);
    chk("oh.uo", 32'(ic.userin_out), 32'h04);
    tick(6'b000001, 1'b0, 1'b0);
    chk("oh.hold", 32'(ic.userin_out), 32'h04);

    tick(6'd0, 1'b0, 1'b1);
    // Abort at count 2.
    tick(6'b001000, 1'b0, 1'b0);
    tick(6'd0, 1'b0, 1'b0);
    tick(6'd0, 1'b0, 1'b0);
    chk("clr.cnt", 32'(ia.count), 32'd2);
    tick(6'd0, 1'b1, 1'b0);
    chk("clr.uo", 32'(ia.userin_out), 32'd0);
    chk("clr.busy", 32'(ia.busy), 32'd0);
    tick(6'b001000, 1'b1, 1'b0);
    chk("clr.block", 32'(ia.valid), 32'd0);

    tick(6'b001000, 1'b0, 1'b0);
    tick(6'd0, 1'b0, 1'b0);
    tick(6'd0, 1'b0, 1'b1);
    chk("mrst.uo", 32'(ia.userin_out), 32'd0);
    chk("mrst.cnt", 32'(ia.count), 32'd0);

    cu = '0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(3) == 0)
        cu = ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom);
      tick(cu, $urandom_range(15) == 0,
           $urandom_range(249) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/input_stretcher.md
Name: input_stretcher

Overview:
Parametrised multi-channel button-input conditioner. It captures a non-zero user input vector and holds it stable on the output for a programmable number of cycles. It can isolate a single channel, and it can require the buttons to be released before it accepts another capture. It sits between the debounced button synchronisers and the battle-menu / move-select FSMs. It replaces the fixed 6-bit, 255-cycle extender and its separate counter with one self-contained block.

Parameters:
WIDTH, 6, number of input channels (buttons)
CNT_W, 8, width of the hold counter
HOLD_CYCLES, 255, number of cycles the captured value is driven; legal range 1 .. 2^CNT_W-1
REQUIRE_RELEASE, 1, 1 = all inputs must return to zero before a new capture; 0 = recapture allowed immediately
ONEHOT_MODE, 0, 1 = capture only the lowest-index set bit; 0 = capture the full vector

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
userin  input  WIDTH  raw (already synchronised) button vector
clear  input  1  synchronous abort of the current hold
userin_out  output  WIDTH  held input value; zero when not holding
valid  output  1  high on every cycle that userin_out is non-zero (HOLD state)
captured  output  1  one-cycle pulse on the first HOLD cycle
busy  output  1  high in HOLD or RELEASE_WAIT
count  output  CNT_W  cycles elapsed in current hold, 0 .. HOLD_CYCLES-1; zero outside HOLD

Behaviour:
- Reset: clocked on clk, synchronous, active-high. All outputs are registered and reset to 0. State resets to IDLE. Reset has priority over clear and userin.
- States: IDLE, HOLD, RELEASE_WAIT.
- IDLE:
  - Outputs are 0.
  - If userin != 0 at edge N: enter HOLD at edge N.
  - userin_out loads the captured value: userin if ONEHOT_MODE=0, else userin & -userin (lowest set bit).
  - count loads 0; captured=1 for that cycle.
  - Latency: input sampled at edge N, output visible after edge N.
- HOLD:
  - userin_out is constant; changes on userin are ignored.
  - count increments by 1 per cycle.
  - At the edge where count == HOLD_CYCLES-1, leave HOLD and clear userin_out, valid and count. Next state:
    - RELEASE_WAIT if REQUIRE_RELEASE=1 and userin != 0 on that edge;
    - otherwise IDLE.
  - userin_out is therefore non-zero for exactly HOLD_CYCLES consecutive cycles.
  - HOLD_CYCLES=1 gives a single-cycle pulse.
- RELEASE_WAIT:
  - Outputs are 0; busy=1.
  - Return to IDLE on the first edge where userin == 0.
  - A new capture can occur no earlier than the cycle after that return.
- REQUIRE_RELEASE=0: from the end of HOLD the block goes to IDLE. A still-held input recaptures on the following edge, giving a one-cycle zero gap between holds.
- clear:
  - In HOLD: outputs go to 0 on the same edge. Next state is RELEASE_WAIT if REQUIRE_RELEASE=1 and userin != 0, else IDLE.
  - In IDLE: clear blocks capture on that edge.
  - In RELEASE_WAIT: clear has no effect.
- Counter: never wraps, because the HOLD exit occurs at HOLD_CYCLES-1. HOLD_CYCLES outside the legal range is an elaboration error (assertion).
- ONEHOT_MODE example: userin=6'b101100 captures 6'b000100.

Decomposition:
- Shared package input_pkg:
  - state enum {IDLE, HOLD, RELEASE_WAIT};
  - default constants DEFAULT_WIDTH=6, DEFAULT_HOLD=255.
- One sub-module, input_lsb_isolate: combinational, parametrised on WIDTH, returns the lowest set bit of the vector. It is instantiated only when ONEHOT_MODE=1.
- The FSM, counter and output registers stay in input_stretcher.

Test Plan:
- Reset then userin=6'b000100 for 1 cycle (HOLD_CYCLES=4) -> userin_out=6'b000100 and valid=1 for exactly 4 cycles; count 0,1,2,3; captured=1 only on the first cycle; then all outputs 0.
- userin=6'b000010 held for 20 cycles, REQUIRE_RELEASE=1, HOLD_CYCLES=4 -> one 4-cycle hold, then busy=1 and userin_out=0 until release; after release plus one cycle, a new press captures again.
- Same stimulus with REQUIRE_RELEASE=0 -> repeating pattern of 4 cycles 6'b000010, 1 cycle 0.
- ONEHOT_MODE=1, userin=6'b110100 -> userin_out=6'b000100. During HOLD, change userin to 6'b000001 -> output unchanged.
- clear asserted at count=2 with userin=0 -> outputs 0 on the next edge, state IDLE. Reset asserted mid-HOLD -> all outputs 0 next edge, count=0.
- HOLD_CYCLES=1 with a 1-cycle press -> valid high for exactly one cycle, captured coincident with it.
